// File: rtl/gsim_matvec.sv
// Banded matrix-vector product b = A*x on a streamed Q16.16 frame using a
// 7-tap sliding window; the tail rows are drained with three zero-fill flush steps.
module gsim_matvec #(
  parameter int N_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [31:0] x_in,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] b_out
);

  // Handshake: a sample moves on a cycle where in_en && in_ready; out_valid is a
  // one-cycle strobe with no back-pressure, and b_out holds its value otherwise.

  localparam int KW = $clog2(N_LEN + 1);

  typedef enum logic {
    S_LOAD  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [1:0]         fcnt_q, fcnt_d;
  logic signed [31:0] win_q [7];
  logic signed [31:0] win_d [7];
  logic signed [31:0] sh    [7];
  logic [15:0]        b_q, b_d;
  logic               vld_q, vld_d;
  logic               accept;
  logic signed [39:0] acc, rnd, shr;
  logic [15:0]        row_sat;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = vld_q;
  assign b_out     = b_q;

  // sh is the window as it looks after this cycle's step; sh[3] is the centre tap.
  always_comb begin
    accept = in_en && (state_q == S_LOAD);
    sh[0]  = accept ? $signed(x_in) : 32'sd0;
    for (int i = 1; i < 7; i++) sh[i] = win_q[i-1];
    acc = -40'(sh[0]) + 40'sd6 * 40'(sh[1]) - 40'sd13 * 40'(sh[2])
        + 40'sd20 * 40'(sh[3]) - 40'sd13 * 40'(sh[4]) + 40'sd6 * 40'(sh[5])
        - 40'(sh[6]);
    rnd = acc + 40'sd32768;
    shr = rnd >>> 16;
    if (shr > 40'sd32767)       row_sat = 16'h7FFF;
    else if (shr < -40'sd32768) row_sat = 16'h8000;
    else                        row_sat = shr[15:0];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    fcnt_d  = fcnt_q;
    win_d   = win_q;
    vld_d   = 1'b0;
    b_d     = b_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          win_d = sh;
          k_d   = k_q + KW'(1);
          if (k_q >= KW'(3)) begin
            vld_d = 1'b1;
            b_d   = row_sat;
          end
          if (k_q == KW'(N_LEN - 1)) begin
            state_d = S_FLUSH;
            fcnt_d  = 2'd0;
          end
        end
      end
      S_FLUSH: begin
        win_d  = sh;
        vld_d  = 1'b1;
        b_d    = row_sat;
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'd2) begin
          state_d = S_LOAD;
          k_d     = '0;
          for (int i = 0; i < 7; i++) win_d[i] = 32'sd0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      fcnt_q  <= 2'd0;
      vld_q   <= 1'b0;
      b_q     <= 16'h0000;
      for (int i = 0; i < 7; i++) win_q[i] <= 32'sd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fcnt_q  <= fcnt_d;
      vld_q   <= vld_d;
      b_q     <= b_d;
      for (int i = 0; i < 7; i++) win_q[i] <= win_d[i];
    end
  end

endmodule

// File: tb/tb_gsim_matvec.sv
// Directed bench for gsim_matvec: impulse, constant, saturation, rounding,
// gap/flush-ignore and mid-frame reset frames against hand-computed rows.
module tb_gsim_matvec;

  localparam int N = 16;

  logic        clk;
  logic        reset;
  logic        in_en;
  logic [31:0] x_in;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] b_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  int imp_b [N] = '{20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int cst_b [N] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
  int sat_b [N] = '{32767, -32767, 32767, 32767, 32767, 32767, 32767, 32767,
                    32767, 32767, 32767, 32767, 32767, 32767, -32767, 32767};
  int rnd_b [N] = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  gsim_matvec #(.N_LEN(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] x_of(input int kind, input int k);
    case (kind)
      0:       return (k == 0) ? 32'h0001_0000 : 32'h0;
      1:       return 32'h0001_0000;
      2:       return 32'h7FFF_0000;
      default: return (k == 0) ? 32'h0000_8000 : 32'h0;
    endcase
  endfunction

  function automatic int b_of(input int kind, input int r);
    case (kind)
      0:       return imp_b[r];
      1:       return cst_b[r];
      2:       return sat_b[r];
      default: return rnd_b[r];
    endcase
  endfunction

  // scoreboard: every out_valid pops one expected value and cycle
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_row", 32'd1, 32'd0);
      end else begin
        check("row_val", {16'h0, b_out}, {16'h0, exp_q.pop_front()});
        check("row_cyc", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // driver: one frame; gap_at inserts 2 idle cycles after that sample,
  // stop_at asserts reset instead of driving that sample
  task automatic run_frame(input int kind, input int gap_at, input bit flush_en,
                           input int stop_at);
    int c0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == stop_at) begin
        in_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", {31'h0, out_valid}, 32'd0);
        check("rst_mid_b", {16'h0, b_out}, 32'd0);
        check("rst_mid_ready", {31'h0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (k == 0) begin
        c0 = cyc;
        check("ready_load", {31'h0, in_ready}, 32'd1);
        for (int r = 0; r < N; r++) begin
          if (stop_at < 0 || r + 3 < stop_at) begin
            exp_q.push_back(16'(b_of(kind, r)));
            exp_cyc_q.push_back(c0 + 4 + r + ((gap_at >= 0 && r + 3 > gap_at) ? 2 : 0));
          end
        end
      end
      in_en = 1'b1;
      x_in  = x_of(kind, k);
      if (k == gap_at) begin
        repeat (2) begin
          @(negedge clk);
          in_en = 1'b0;
          x_in  = $urandom;
        end
      end
    end
    repeat (3) begin
      @(negedge clk);
      check("ready_flush", {31'h0, in_ready}, 32'd0);
      in_en = flush_en;
      x_in  = 32'h7FFF_0000;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    x_in  = 32'h0;
    #3;
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_b", {16'h0, b_out}, 32'd0);
    check("rst_ready", {31'h0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_frame(0, -1, 1'b0, -1);
    run_frame(1, -1, 1'b0, -1);
    run_frame(2, -1, 1'b0, -1);
    run_frame(3, -1, 1'b0, -1);
    run_frame(1, 5, 1'b1, -1);
    run_frame(0, -1, 1'b0, -1);
    run_frame(1, -1, 1'b0, 8);
    run_frame(0, -1, 1'b0, -1);
    @(negedge clk);
    in_en = 1'b0;

    repeat (30) @(negedge clk);
    check("rows_pending", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gsim_matvec.md
GSIM_MATVEC -- requirements
Module: gsim_matvec

Interface
REQ-001 SHALL have parameter N_LEN, default 16, meaning samples per frame (legal range 7..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_en, input, 1 bit: x_in is valid this cycle.
REQ-005 SHALL have port x_in, input, 32 bits: signed two's-complement Q16.16 solution sample x[k].
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts x_in this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: b_out holds a new row result.
REQ-008 SHALL have port b_out, output, 16 bits: signed integer b[i] = (A*x)[i].

Function
REQ-009 SHALL compute b[i] = -x[i-3] + 6x[i-2] - 13x[i-1] + 20x[i] - 13x[i+1] + 6x[i+2] - x[i+3] for i = 0..N_LEN-1.
REQ-010 SHALL treat x at indices below 0 or above N_LEN-1 as zero.
REQ-011 SHALL accept a sample only when in_en and in_ready are both 1 in the same cycle.
REQ-012 SHALL keep a 7-entry sample window, shifting in the newest sample on each accept.
REQ-013 SHALL have state LOAD, with in_ready=1 and accept counter k running 0..N_LEN-1.
REQ-014 SHALL have state FLUSH, with in_ready=0; it lasts exactly 3 cycles and shifts a zero into the window each cycle.
REQ-015 SHALL transition LOAD->FLUSH on the accept of sample N_LEN-1, and FLUSH->LOAD after the third flush cycle.
REQ-016 SHALL clear the window and set k=0 on the FLUSH->LOAD transition.
REQ-017 SHALL compute row k-3 when sample k (k>=3) is accepted, and row N_LEN-3+j on flush cycle j (j=0..2).
REQ-018 SHALL register each row result, asserting out_valid for one cycle in the cycle after the accept or flush step that produced it.
REQ-019 SHALL assert out_valid exactly N_LEN times per frame, in row order 0..N_LEN-1.
REQ-020 SHALL produce out_valid in cycles 4..N_LEN+3, counted from the first accept at cycle 0, when input is gapless.
REQ-021 SHALL hold out_valid=0 and b_out unchanged during input gaps (in_en=0 in LOAD); gaps shall not alter results.
REQ-022 SHALL ignore in_en during FLUSH: no accept and no counter change.
REQ-023 SHALL accumulate in at least 40-bit signed arithmetic with no intermediate overflow.
REQ-024 SHALL round by adding 0x8000 to the Q16.16 sum, then arithmetic-shifting right by 16 (round half toward +inf).
REQ-025 SHALL saturate the rounded result to [-32768, 32767].
REQ-026 SHALL allow a new frame's sample 0 to be accepted in the first cycle after FLUSH ends.

Reset
REQ-027 SHALL, while reset=1 (asynchronously), force state=LOAD, k=0, window=0, out_valid=0, b_out=0 and in_ready=1.
REQ-028 SHALL abandon a frame when reset is asserted mid-frame, emitting no further rows for it; the next frame SHALL compute correctly.

Verification
REQ-029 SHALL verify reset: assert reset at any time -> out_valid=0, b_out=0x0000, in_ready=1 immediately.
REQ-030 SHALL verify impulse: x0=0x00010000, x1..x15=0, gapless -> b=20,-13,6,-1, then 0 x12; out_valid high cycles 4..19.
REQ-031 SHALL verify constant input: all x=0x00010000 -> b=12,-1,5, then 4 x10, then 5,-1,12.
REQ-032 SHALL verify saturation: all x=0x7FFF0000 -> b0=32767, b1=-32767, b2=32767, b3..b12=32767.
REQ-033 SHALL verify rounding: x0=0x00008000, rest 0 -> b0=10, b1=-6, b2=3, b3=0.
REQ-034 SHALL verify gaps and reset: a 2-cycle in_en gap after x5 delays out_valid with results identical to the constant case; in_en=1 during FLUSH is ignored; reset at k=8, then a new impulse frame -> the REQ-030 results.
